// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FIFO sizing defaults and the wrap-bit pointer increment.
// Used by the memory, fifo_ctrl and the bench so all agree on pointer layout.
package fifo_ctrl_pkg;

   localparam int unsigned MEM_SIZE_DEF = 4;
   localparam int unsigned PTR_L_DEF    = 3;
   localparam int unsigned ADDR_W_DEF   = PTR_L_DEF - 1;

   // Modulo-2**w increment of a pointer carried in a 32-bit container.
   function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return (p + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/flag/pointer bundle between the FIFO users, fifo_ctrl and memory.
//   master : producer/consumer side (drives requests and thresholds)
//   slave  : fifo_ctrl side (drives pointers, enables, count, flags, errors)
interface fifo_ctrl_if #(
   parameter int unsigned PTR_L = fifo_ctrl_pkg::PTR_L_DEF
);
   logic             push_req;
   logic             pop_req;
   logic [PTR_L-1:0] af_thresh;
   logic [PTR_L-1:0] ae_thresh;
   logic [PTR_L-1:0] wr_ptr;
   logic [PTR_L-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [PTR_L-1:0] count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             data_valid;
   logic             overflow;
   logic             underflow;

   modport master (
      output push_req, pop_req, af_thresh, ae_thresh,
      input  wr_ptr, rd_ptr, push, pop, count, full, empty,
             almost_full, almost_empty, data_valid, overflow, underflow
   );

   modport slave (
      input  push_req, pop_req, af_thresh, ae_thresh,
      output wr_ptr, rd_ptr, push, pop, count, full, empty,
             almost_full, almost_empty, data_valid, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: PTR_L-bit pointer (address bits + wrap MSB) advancing by one when enabled.
//   clk, reset : clock and asynchronous active-high reset
//   i_en       : advance pointer on this edge
//   o_ptr      : current pointer value
module fifo_ptr
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned PTR_L = PTR_L_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   output logic [PTR_L-1:0] o_ptr
);

   logic [PTR_L-1:0] r_ptr;

   // Full-width wrap: address rolls MEM_SIZE-1 -> 0 while the MSB toggles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_ptr <= '0;
      else if (i_en) r_ptr <= PTR_L'(ptr_inc(32'(r_ptr), PTR_L));
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO control unit driving memory pointers/enables and occupancy flags.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : fifo_ctrl_if.slave -- push_req/pop_req/thresholds in; wr_ptr, rd_ptr,
//                push, pop, count, full, empty, almost flags, data_valid, overflow,
//                underflow out
module fifo_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
   parameter int unsigned PTR_L    = PTR_L_DEF
) (
   input  logic        clk,
   input  logic        reset,
   fifo_ctrl_if.slave  bus
);

   localparam int unsigned ADDR_W = PTR_L - 1;

   logic [PTR_L-1:0] w_wr_ptr;
   logic [PTR_L-1:0] w_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [PTR_L-1:0] r_count;
   logic             r_data_valid;
   logic             r_overflow;
   logic             r_underflow;

   // Occupancy derived from pointers: same address with differing wrap bits means full.
   assign w_empty = (w_wr_ptr == w_rd_ptr);
   assign w_full  = (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]) &&
                    (w_wr_ptr[PTR_L-1] != w_rd_ptr[PTR_L-1]);

   // Qualified enables go straight to memory in the request cycle.
   assign w_push = bus.push_req & ~w_full;
   assign w_pop  = bus.pop_req  & ~w_empty;

   fifo_ptr #(.PTR_L(PTR_L)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_push),
      .o_ptr (w_wr_ptr)
   );

   fifo_ptr #(.PTR_L(PTR_L)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_pop),
      .o_ptr (w_rd_ptr)
   );

   // Occupancy counter; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + PTR_L'(1);
            2'b01:   r_count <= r_count - PTR_L'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Read strobe aligned with the memory's registered output, plus sticky errors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_data_valid <= w_pop;
         r_overflow   <= r_overflow  | (bus.push_req & w_full);
         r_underflow  <= r_underflow | (bus.pop_req  & w_empty);
      end
   end

   assign bus.wr_ptr       = w_wr_ptr;
   assign bus.rd_ptr       = w_rd_ptr;
   assign bus.push         = w_push;
   assign bus.pop          = w_pop;
   assign bus.count        = r_count;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.almost_full  = (r_count >= bus.af_thresh);
   assign bus.almost_empty = (r_count <= bus.ae_thresh);
   assign bus.data_valid   = r_data_valid;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

   // Counter must track the pointer difference, and full must coincide with MEM_SIZE.
   a_count_matches_ptrs: assert property (@(posedge clk) disable iff (reset)
      r_count == PTR_L'(w_wr_ptr - w_rd_ptr));
   a_full_matches_count: assert property (@(posedge clk) disable iff (reset)
      w_full == (r_count == PTR_L'(MEM_SIZE)));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a small memory model on its enables.
module tb_fifo_ctrl;
   import fifo_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic [7:0] dout;
   logic [7:0] mem [4];
   int         checks;
   int         errors;

   fifo_ctrl_if #(.PTR_L(3)) bus ();

   fifo_ctrl #(.MEM_SIZE(4), .PTR_L(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: write on push, registered read on pop.
   always_ff @(posedge clk) begin
      if (bus.push) mem[bus.wr_ptr[1:0]] <= din;
      if (bus.pop)  dout <= mem[bus.rd_ptr[1:0]];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      bus.af_thresh = 3'd3;
      bus.ae_thresh = 3'd1;
      din = 8'h00;
      do_reset();
      step();
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty actual=%b required=1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full actual=%b required=0", bus.full); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", bus.count); end
      checks++; if (bus.wr_ptr !== 3'd0) begin errors++; $display("FAIL reset_wr_ptr actual=%0d required=0", bus.wr_ptr); end
      checks++; if (bus.rd_ptr !== 3'd0) begin errors++; $display("FAIL reset_rd_ptr actual=%0d required=0", bus.rd_ptr); end
      checks++; if ({bus.push, bus.pop, bus.data_valid} !== 3'b000) begin errors++; $display("FAIL reset_enables actual=%b required=000", {bus.push, bus.pop, bus.data_valid}); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_errors actual=%b required=00", {bus.overflow, bus.underflow}); end
      checks++; if ({bus.almost_full, bus.almost_empty} !== 2'b01) begin errors++; $display("FAIL reset_almost actual=%b required=01", {bus.almost_full, bus.almost_empty}); end
   endtask

   task automatic test_fill();
      bus.af_thresh = 3'd3;
      for (int i = 0; i < 4; i++) begin
         bus.push_req = 1'b1;
         din = 8'hA0 + 8'(i);
         #1;
         checks++; if (bus.push !== 1'b1) begin errors++; $display("FAIL fill_push[%0d] actual=%b required=1", i, bus.push); end
         step();
         checks++; if (bus.wr_ptr !== 3'(i + 1)) begin errors++; $display("FAIL fill_wr_ptr[%0d] actual=%0d required=%0d", i, bus.wr_ptr, i + 1); end
         checks++; if (bus.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] actual=%0d required=%0d", i, bus.count, i + 1); end
         checks++; if (bus.almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_almost_full[%0d] actual=%b required=%b", i, bus.almost_full, i >= 2); end
         checks++; if (bus.full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d] actual=%b required=%b", i, bus.full, i == 3); end
      end
      din = 8'hEE;
      #1;
      checks++; if (bus.push !== 1'b0) begin errors++; $display("FAIL fill_push_blocked actual=%b required=0", bus.push); end
      step();
      bus.push_req = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow actual=%b required=1", bus.overflow); end
      checks++; if (bus.wr_ptr !== 3'd4) begin errors++; $display("FAIL fill_wr_ptr_hold actual=%0d required=4", bus.wr_ptr); end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count_hold actual=%0d required=4", bus.count); end
   endtask

   task automatic test_drain();
      bus.ae_thresh = 3'd1;
      for (int i = 0; i < 4; i++) begin
         bus.pop_req = 1'b1;
         #1;
         checks++; if (bus.pop !== 1'b1) begin errors++; $display("FAIL drain_pop[%0d] actual=%b required=1", i, bus.pop); end
         step();
         checks++; if (bus.rd_ptr !== 3'(i + 1)) begin errors++; $display("FAIL drain_rd_ptr[%0d] actual=%0d required=%0d", i, bus.rd_ptr, i + 1); end
         checks++; if (bus.count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] actual=%0d required=%0d", i, bus.count, 3 - i); end
         checks++; if (bus.data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] actual=%b required=1", i, bus.data_valid); end
         checks++; if (dout !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d] actual=%h required=%h", i, dout, 8'hA0 + 8'(i)); end
         checks++; if (bus.almost_empty !== (i >= 2)) begin errors++; $display("FAIL drain_almost_empty[%0d] actual=%b required=%b", i, bus.almost_empty, i >= 2); end
      end
      bus.pop_req = 1'b0;
      step();
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_drop actual=%b required=0", bus.data_valid); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty actual=%b required=1", bus.empty); end
      checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_no_underflow actual=%b required=0", bus.underflow); end
      bus.pop_req = 1'b1;
      #1;
      checks++; if (bus.pop !== 1'b0) begin errors++; $display("FAIL drain_pop_blocked actual=%b required=0", bus.pop); end
      step();
      bus.pop_req = 1'b0;
      checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow actual=%b required=1", bus.underflow); end
      checks++; if (bus.rd_ptr !== 3'd4) begin errors++; $display("FAIL drain_rd_ptr_hold actual=%0d required=4", bus.rd_ptr); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL drain_extra_valid actual=%b required=0", bus.data_valid); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.push_req = 1'b1;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         bus.pop_req = 1'b1;
         #1;
         checks++; if ({bus.push, bus.pop} !== 2'b11) begin errors++; $display("FAIL b2b_enables[%0d] actual=%b required=11", i, {bus.push, bus.pop}); end
         step();
         checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] actual=%0d required=2", i, bus.count); end
      end
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      checks++; if (bus.wr_ptr !== 3'd5) begin errors++; $display("FAIL b2b_wr_ptr actual=%0d required=5", bus.wr_ptr); end
      checks++; if (bus.rd_ptr !== 3'd3) begin errors++; $display("FAIL b2b_rd_ptr actual=%0d required=3", bus.rd_ptr); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL b2b_errors actual=%b required=00", {bus.overflow, bus.underflow}); end
   endtask

   task automatic test_edge_full();
      do_reset();
      bus.push_req = 1'b1;
      for (int i = 0; i < 4; i++) step();
      bus.pop_req = 1'b1;
      #1;
      checks++; if ({bus.push, bus.pop} !== 2'b01) begin errors++; $display("FAIL full_simul_enables actual=%b required=01", {bus.push, bus.pop}); end
      step();
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_simul_count actual=%0d required=3", bus.count); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b10) begin errors++; $display("FAIL full_simul_errors actual=%b required=10", {bus.overflow, bus.underflow}); end
      checks++; if ({bus.wr_ptr, bus.rd_ptr} !== {3'd4, 3'd1}) begin errors++; $display("FAIL full_simul_ptrs actual=%0d/%0d required=4/1", bus.wr_ptr, bus.rd_ptr); end
   endtask

   task automatic test_edge_empty();
      do_reset();
      bus.push_req = 1'b1;
      bus.pop_req  = 1'b1;
      #1;
      checks++; if ({bus.push, bus.pop} !== 2'b10) begin errors++; $display("FAIL empty_simul_enables actual=%b required=10", {bus.push, bus.pop}); end
      step();
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL empty_simul_count actual=%0d required=1", bus.count); end
      checks++; if ({bus.overflow, bus.underflow} !== 2'b01) begin errors++; $display("FAIL empty_simul_errors actual=%b required=01", {bus.overflow, bus.underflow}); end
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL empty_simul_valid actual=%b required=0", bus.data_valid); end
      checks++; if ({bus.wr_ptr, bus.rd_ptr} !== {3'd1, 3'd0}) begin errors++; $display("FAIL empty_simul_ptrs actual=%0d/%0d required=1/0", bus.wr_ptr, bus.rd_ptr); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.push_req = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.push_req = 1'b0;
      bus.af_thresh = 3'd4;
      #1;
      checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL thresh_af4 actual=%b required=0", bus.almost_full); end
      bus.af_thresh = 3'd2;
      bus.ae_thresh = 3'd3;
      #1;
      checks++; if ({bus.almost_full, bus.almost_empty} !== 2'b11) begin errors++; $display("FAIL thresh_af2_ae3 actual=%b required=11", {bus.almost_full, bus.almost_empty}); end
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_pre_count actual=%0d required=3", bus.count); end
      reset = 1'b1;
      #1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count actual=%0d required=0", bus.count); end
      checks++; if ({bus.wr_ptr, bus.rd_ptr} !== 6'd0) begin errors++; $display("FAIL mid_ptrs actual=%0d/%0d required=0/0", bus.wr_ptr, bus.rd_ptr); end
      checks++; if ({bus.empty, bus.full} !== 2'b10) begin errors++; $display("FAIL mid_flags actual=%b required=10", {bus.empty, bus.full}); end
      step();
      reset = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset        = 1'b1;
      bus.push_req = 1'b0;
      bus.pop_req  = 1'b0;
      bus.af_thresh = 3'd3;
      bus.ae_thresh = 3'd1;
      din = 8'h00;
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_edge_full();
      test_edge_empty();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
